sort_result_streamer: RTL and testbench

Back end of the register sorting network: when the sorter raises its sticky `done`, this block captures the full parallel result (SLICES data words plus their source indices). It re-arms the sorter with a one-cycle clear pulse, then streams the captured words out one per beat on a valid/ready interface, in rank order. It is the reader side of the sorter's parallel output and sits between the sorter and downstream symbol/peak-selection logic. SLICE_WIDTH and INDEX_WIDTH come from `core_params.svh`.

---
 rtl/sort_result_streamer.sv | 114 +++++++++++
 tb/tb_sort_result_streamer.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sort_result_streamer.sv
// ============================================================================
// Module   : sort_result_streamer
// Brief    : Captures the sorter's parallel result on done, pulses a clear back
//            to the sorter, then streams the words out in rank order (valid/ready).
// Revision : 1.0
// ============================================================================
`default_nettype none

module sort_result_streamer #(
    parameter int SLICES      = 4,
    parameter int FIRST_HIGH  = 0,
    parameter int SLICE_WIDTH = 16,
    parameter int INDEX_WIDTH = 8
) (
    input  logic                                    clk,
    input  logic                                    reset,
    input  logic                                    sort_done,
    input  logic [SLICES-1:0][SLICE_WIDTH-1:0]      sort_data,
    input  logic [SLICES-1:0][INDEX_WIDTH-1:0]      sort_index,
    output logic                                    sort_clear,
    output logic                                    out_valid,
    input  logic                                    out_ready,
    output logic [SLICE_WIDTH-1:0]                  out_data,
    output logic [INDEX_WIDTH-1:0]                  out_index,
    output logic [$clog2(SLICES)-1:0]               out_rank,
    output logic                                    out_last,
    output logic                                    busy,
    output logic [15:0]                             frame_count
);

    localparam int              RW        = $clog2(SLICES);
    localparam logic [RW-1:0]   LAST_RANK = RW'(SLICES - 1);

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } state_t;

    state_t                             r_state;
    logic [SLICES-1:0][SLICE_WIDTH-1:0] r_data_buf;
    logic [SLICES-1:0][INDEX_WIDTH-1:0] r_index_buf;
    logic [RW-1:0]                      r_ptr;

    logic [RW-1:0]                      w_next_ptr;
    logic [RW-1:0]                      w_first_lane;
    logic [RW-1:0]                      w_next_lane;

    // SLICES is a power of two, so SLICES-1-k is simply the bitwise complement.
    function automatic logic [RW-1:0] lane_of(input logic [RW-1:0] rank);
        return (FIRST_HIGH != 0) ? ~rank : rank;
    endfunction

    assign w_next_ptr   = r_ptr + RW'(1);
    assign w_first_lane = lane_of('0);
    assign w_next_lane  = lane_of(w_next_ptr);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= IDLE;
            r_data_buf  <= '0;
            r_index_buf <= '0;
            r_ptr       <= '0;
            sort_clear  <= 1'b0;
            out_valid   <= 1'b0;
            out_data    <= '0;
            out_index   <= '0;
            out_rank    <= '0;
            out_last    <= 1'b0;
            busy        <= 1'b0;
            frame_count <= 16'd0;
        end else begin
            sort_clear <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (sort_done) begin
                        // Beat 0 is loaded straight from the inputs so it is valid next cycle.
                        r_data_buf  <= sort_data;
                        r_index_buf <= sort_index;
                        r_ptr       <= '0;
                        sort_clear  <= 1'b1;
                        out_valid   <= 1'b1;
                        out_data    <= sort_data[w_first_lane];
                        out_index   <= sort_index[w_first_lane];
                        out_rank    <= '0;
                        out_last    <= 1'b0;
                        busy        <= 1'b1;
                        r_state     <= STREAM;
                    end
                end
                STREAM: begin
                    if (out_ready) begin
                        if (r_ptr == LAST_RANK) begin
                            out_valid   <= 1'b0;
                            out_last    <= 1'b0;
                            busy        <= 1'b0;
                            frame_count <= frame_count + 16'd1;
                            r_state     <= IDLE;
                        end else begin
                            r_ptr     <= w_next_ptr;
                            out_data  <= r_data_buf[w_next_lane];
                            out_index <= r_index_buf[w_next_lane];
                            out_rank  <= w_next_ptr;
                            out_last  <= (w_next_ptr == LAST_RANK);
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_sort_result_streamer.sv
// ============================================================================
// Module   : tb_sort_result_streamer
// Brief    : Self-checking bench; runs FIRST_HIGH=0 and FIRST_HIGH=1 instances
//            in lockstep against table vectors and a rank-order reference model.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_sort_result_streamer;

    localparam int S  = 4;
    localparam int DW = 16;
    localparam int IW = 8;

    logic                   clk = 1'b0;
    logic                   reset = 1'b1;
    logic                   sort_done = 1'b0;
    logic [S-1:0][DW-1:0]   sort_data = '0;
    logic [S-1:0][IW-1:0]   sort_index = '0;
    logic                   out_ready = 1'b0;

    logic                   sort_clear0, out_valid0, out_last0, busy0;
    logic [DW-1:0]          out_data0;
    logic [IW-1:0]          out_index0;
    logic [1:0]             out_rank0;
    logic [15:0]            frame_count0;

    logic                   sort_clear1, out_valid1, out_last1, busy1;
    logic [DW-1:0]          out_data1;
    logic [IW-1:0]          out_index1;
    logic [1:0]             out_rank1;
    logic [15:0]            frame_count1;

    int                     checks = 0;
    int                     failures = 0;
    logic [15:0]            exp_fc = 16'd0;

    always #5 clk = ~clk;

    sort_result_streamer #(.SLICES(S), .FIRST_HIGH(0), .SLICE_WIDTH(DW), .INDEX_WIDTH(IW)) dut0 (
        .clk(clk), .reset(reset), .sort_done(sort_done), .sort_data(sort_data),
        .sort_index(sort_index), .sort_clear(sort_clear0), .out_valid(out_valid0),
        .out_ready(out_ready), .out_data(out_data0), .out_index(out_index0),
        .out_rank(out_rank0), .out_last(out_last0), .busy(busy0), .frame_count(frame_count0)
    );

    sort_result_streamer #(.SLICES(S), .FIRST_HIGH(1), .SLICE_WIDTH(DW), .INDEX_WIDTH(IW)) dut1 (
        .clk(clk), .reset(reset), .sort_done(sort_done), .sort_data(sort_data),
        .sort_index(sort_index), .sort_clear(sort_clear1), .out_valid(out_valid1),
        .out_ready(out_ready), .out_data(out_data1), .out_index(out_index1),
        .out_rank(out_rank1), .out_last(out_last1), .busy(busy1), .frame_count(frame_count1)
    );

    // Expected words/indices are listed in beat order: element [k] is beat k.
    typedef struct {
        logic [S-1:0][DW-1:0] data;
        logic [S-1:0][IW-1:0] idx;
        logic [S-1:0][DW-1:0] ed0;
        logic [S-1:0][IW-1:0] ei0;
        logic [S-1:0][DW-1:0] ed1;
        logic [S-1:0][IW-1:0] ei1;
        int                   stall_beat;
        int                   stall_len;
        bit                   corrupt;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model: beat k carries lane k, or lane S-1-k when the high lane goes first.
    function automatic vec_t model(input logic [S-1:0][DW-1:0] d, input logic [S-1:0][IW-1:0] ix);
        vec_t v;
        v.data = d;
        v.idx  = ix;
        for (int k = 0; k < S; k++) begin
            v.ed0[k] = d[k];
            v.ei0[k] = ix[k];
            v.ed1[k] = d[S-1-k];
            v.ei1[k] = ix[S-1-k];
        end
        v.stall_beat = -1;
        v.stall_len  = 0;
        v.corrupt    = 1'b0;
        return v;
    endfunction

    task automatic run_frame(input vec_t v, input bit rnd);
        int beat, cyc, stalls, clr;
        bit rdy;
        chk("idle_valid0", {31'd0, out_valid0}, 32'd0);
        chk("idle_busy1", {31'd0, busy1}, 32'd0);
        sort_data  = v.data;
        sort_index = v.idx;
        sort_done  = 1'b1;
        out_ready  = 1'b1;
        @(posedge clk); #1;
        chk("clear_pulse0", {31'd0, sort_clear0}, 32'd1);
        chk("clear_pulse1", {31'd0, sort_clear1}, 32'd1);
        chk("busy0", {31'd0, busy0}, 32'd1);
        if (v.corrupt) begin
            sort_data  = '1;
            sort_index = '1;
        end
        beat = 0; cyc = 0; stalls = 0; clr = 1;
        while (beat < S && cyc < 200) begin
            if (beat == v.stall_beat && stalls < v.stall_len) begin
                rdy = 1'b0;
                stalls++;
            end else if (rnd) begin
                rdy = 1'($urandom_range(0, 1));
            end else begin
                rdy = 1'b1;
            end
            out_ready = rdy;
            chk("valid0", {31'd0, out_valid0}, 32'd1);
            chk("valid1", {31'd0, out_valid1}, 32'd1);
            chk("data0", {16'd0, out_data0}, {16'd0, v.ed0[beat]});
            chk("index0", {24'd0, out_index0}, {24'd0, v.ei0[beat]});
            chk("rank0", {30'd0, out_rank0}, beat);
            chk("last0", {31'd0, out_last0}, (beat == S-1) ? 32'd1 : 32'd0);
            chk("data1", {16'd0, out_data1}, {16'd0, v.ed1[beat]});
            chk("index1", {24'd0, out_index1}, {24'd0, v.ei1[beat]});
            chk("rank1", {30'd0, out_rank1}, beat);
            chk("last1", {31'd0, out_last1}, (beat == S-1) ? 32'd1 : 32'd0);
            @(posedge clk); #1;
            if (cyc == 0) sort_done = 1'b0;   // sorter saw the clear on this edge
            if (sort_clear0) clr++;
            if (rdy) beat++;
            cyc++;
        end
        if (beat < S) chk("frame_timeout", beat, S);
        exp_fc = exp_fc + 16'd1;
        out_ready = 1'b0;
        chk("frame_count0", {16'd0, frame_count0}, {16'd0, exp_fc});
        chk("frame_count1", {16'd0, frame_count1}, {16'd0, exp_fc});
        chk("end_valid0", {31'd0, out_valid0}, 32'd0);
        chk("end_busy0", {31'd0, busy0}, 32'd0);
        chk("clear_count", clr, 32'd1);
        @(posedge clk); #1;
        chk("no_extra_frame0", {31'd0, out_valid0}, 32'd0);
        chk("no_extra_frame1", {31'd0, out_valid1}, 32'd0);
    endtask

    vec_t vecs [4];
    vec_t rv;

    initial begin
        vecs[0] = '{data: {16'h0040, 16'h0030, 16'h0020, 16'h0010}, idx: {8'd1, 8'd3, 8'd0, 8'd2},
                    ed0: {16'h0040, 16'h0030, 16'h0020, 16'h0010}, ei0: {8'd1, 8'd3, 8'd0, 8'd2},
                    ed1: {16'h0010, 16'h0020, 16'h0030, 16'h0040}, ei1: {8'd2, 8'd0, 8'd3, 8'd1},
                    stall_beat: -1, stall_len: 0, corrupt: 1'b0};
        vecs[1] = vecs[0];
        vecs[1].stall_beat = 1;
        vecs[1].stall_len  = 3;
        vecs[2] = vecs[0];
        vecs[2].corrupt    = 1'b1;
        vecs[2].stall_beat = 0;
        vecs[2].stall_len  = 1;
        vecs[3] = '{data: {16'hDEAD, 16'hBEEF, 16'h1234, 16'h0000}, idx: {8'd7, 8'd6, 8'd5, 8'd4},
                    ed0: {16'hDEAD, 16'hBEEF, 16'h1234, 16'h0000}, ei0: {8'd7, 8'd6, 8'd5, 8'd4},
                    ed1: {16'h0000, 16'h1234, 16'hBEEF, 16'hDEAD}, ei1: {8'd4, 8'd5, 8'd6, 8'd7},
                    stall_beat: 3, stall_len: 2, corrupt: 1'b0};

        repeat (3) @(posedge clk);
        #1;
        chk("rst_clear", {31'd0, sort_clear0}, 32'd0);
        chk("rst_valid", {31'd0, out_valid0}, 32'd0);
        chk("rst_data", {16'd0, out_data0}, 32'd0);
        chk("rst_index", {24'd0, out_index0}, 32'd0);
        chk("rst_rank", {30'd0, out_rank0}, 32'd0);
        chk("rst_last", {31'd0, out_last0}, 32'd0);
        chk("rst_busy", {31'd0, busy1}, 32'd0);
        chk("rst_fc", {16'd0, frame_count1}, 32'd0);
        reset = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < 4; i++) run_frame(vecs[i], 1'b0);

        for (int i = 0; i < 20; i++) begin
            logic [S-1:0][DW-1:0] d;
            logic [S-1:0][IW-1:0] ix;
            for (int k = 0; k < S; k++) begin
                d[k]  = 16'($urandom);
                ix[k] = 8'($urandom);
            end
            rv = model(d, ix);
            rv.corrupt = 1'($urandom_range(0, 1));
            run_frame(rv, 1'b1);
        end

        // Reset while beat 2 is on the bus.
        sort_data  = vecs[0].data;
        sort_index = vecs[0].idx;
        sort_done  = 1'b1;
        out_ready  = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        sort_done = 1'b0;
        @(posedge clk); #1;
        chk("pre_reset_rank", {30'd0, out_rank0}, 32'd2);
        reset = 1'b1;
        @(posedge clk); #1;
        chk("mid_rst_valid", {31'd0, out_valid0}, 32'd0);
        chk("mid_rst_fc", {16'd0, frame_count0}, 32'd0);
        chk("mid_rst_busy", {31'd0, busy1}, 32'd0);
        chk("mid_rst_rank", {30'd0, out_rank1}, 32'd0);
        chk("mid_rst_data", {16'd0, out_data0}, 32'd0);
        reset = 1'b0;
        out_ready = 1'b0;
        exp_fc = 16'd0;
        @(posedge clk); #1;
        run_frame(vecs[3], 1'b0);

        // Preload the counter to its maximum, then one more frame must wrap it.
        @(negedge clk);
        force dut0.frame_count = 16'hFFFF;
        force dut1.frame_count = 16'hFFFF;
        @(posedge clk); #1;
        release dut0.frame_count;
        release dut1.frame_count;
        exp_fc = 16'hFFFF;
        chk("preload_fc", {16'd0, frame_count0}, 32'h0000FFFF);
        run_frame(vecs[0], 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

`default_nettype wire
